// File: rtl/debounce_multi_pkg.sv
// Shared constants and sizing helpers for the multi-channel debouncer.
// Auto-repeat is built only when DEBOUNCE_MULTI_REPEAT_EN is defined.
package debounce_multi_pkg;

  localparam int DEF_N_CH         = 4;
  localparam int DEF_CLK_FREQ_KHZ = 100_000;
  localparam int DEF_DEBOUNCE_MS  = 1;
  localparam int DEF_THRESHOLD    = DEF_CLK_FREQ_KHZ * DEF_DEBOUNCE_MS;
  localparam int DEF_REPEAT_DELAY = DEF_CLK_FREQ_KHZ * 500;
  localparam int DEF_REPEAT_PERIOD = DEF_CLK_FREQ_KHZ * 100;

  // Auto-repeat phase: waiting for the long initial hold, then periodic.
  typedef enum logic {
    RPT_FIRST    = 1'b0,
    RPT_PERIODIC = 1'b1
  } rpt_phase_e;

  // Bits needed for a counter that runs 0 .. limit-1.
  function automatic int cnt_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button bundle between raw switch inputs and the debounced consumer.
// master drives the raw inputs; slave is the debouncer producing levels and pulses.
interface debounce_multi_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] src;
  logic [N_CH-1:0] dst;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] rpt;

  modport master (
    output src,
    input  dst,
    input  rise,
    input  fall,
    input  rpt
  );

  modport slave (
    input  src,
    output dst,
    output rise,
    output fall,
    output rpt
  );

endinterface

// File: rtl/debounce_multi_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, level, edge pulses.
// Optional auto-repeat on long holds when DEBOUNCE_MULTI_REPEAT_EN is defined.
module debounce_chan
  import debounce_multi_pkg::*;
#(
  parameter int   THRESHOLD     = DEF_THRESHOLD,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int   REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic dst,
  output logic rise,
  output logic fall,
  output logic rpt
);

  localparam int            CW       = cnt_width(THRESHOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(THRESHOLD - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          lvl_p2;
  logic          dst_p3;
  logic          dst_d_p4;
  logic          rise_p4;
  logic          fall_p4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= RESET_LEVEL;
      sync_p1  <= RESET_LEVEL;
      cnt      <= '0;
      lvl_p2   <= RESET_LEVEL;
      dst_p3   <= RESET_LEVEL;
      dst_d_p4 <= RESET_LEVEL;
      rise_p4  <= 1'b0;
      fall_p4  <= 1'b0;
    end else begin
      // p0/p1: metastability filter on the raw asynchronous input
      sync_p0 <= src;
      sync_p1 <= sync_p0;

      // p2: accepted level flips only after THRESHOLD consecutive disagreeing samples
      if (sync_p1 == lvl_p2) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl_p2 <= ~lvl_p2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // p3: registered debounced output
      dst_p3 <= lvl_p2;

      // p4: edge pulses one cycle after the output level changes
      dst_d_p4 <= dst_p3;
      rise_p4  <= dst_p3 & ~dst_d_p4;
      fall_p4  <= ~dst_p3 & dst_d_p4;
    end
  end

  assign dst  = dst_p3;
  assign rise = rise_p4;
  assign fall = fall_p4;

`ifdef DEBOUNCE_MULTI_REPEAT_EN
  localparam int            HW       = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold;
  rpt_phase_e    phase;
  logic          rpt_p4;

  // Gating on lvl_p2 as well as dst_p3 kills a pending pulse on the edge the output falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold   <= '0;
      phase  <= RPT_FIRST;
      rpt_p4 <= 1'b0;
    end else if (!(dst_p3 && lvl_p2)) begin
      hold   <= '0;
      phase  <= RPT_FIRST;
      rpt_p4 <= 1'b0;
    end else if (hold == ((phase == RPT_FIRST) ? DLY_LAST : PER_LAST)) begin
      hold   <= '0;
      phase  <= RPT_PERIODIC;
      rpt_p4 <= 1'b1;
    end else begin
      hold   <= hold + 1'b1;
      rpt_p4 <= 1'b0;
    end
  end

  assign rpt = rpt_p4;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer / edge detector: one independent debounce_chan per input bit.
// Define DEBOUNCE_MULTI_REPEAT_EN to add per-channel auto-repeat pulses.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int   N_CH          = DEF_N_CH,
  parameter int   CLK_FREQ_KHZ  = DEF_CLK_FREQ_KHZ,
  parameter int   DEBOUNCE_MS   = DEF_DEBOUNCE_MS,
  parameter int   THRESHOLD     = CLK_FREQ_KHZ * DEBOUNCE_MS,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   REPEAT_DELAY  = CLK_FREQ_KHZ * 500,
  parameter int   REPEAT_PERIOD = CLK_FREQ_KHZ * 100
) (
  input  logic              clk,
  input  logic              rst_n,
  debounce_multi_if.slave   bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .THRESHOLD     (THRESHOLD),
      .RESET_LEVEL   (RESET_LEVEL),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .src   (bus.src[i]),
      .dst   (bus.dst[i]),
      .rise  (bus.rise[i]),
      .fall  (bus.fall[i]),
      .rpt   (bus.rpt[i])
    );
  end

endmodule
